fifo_in_buffer: RTL and testbench

//  Ingress counterpart of the NIC egress buffer: receives flits of one input VC from the router link,

---
 rtl/fifo_in_buffer_pkg.sv | 37 +++
 rtl/fifo_in_buffer_credit_return.sv | 46 ++++
 rtl/fifo_in_buffer.sv | 140 ++++++++++++++
 tb/tb_fifo_in_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_in_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_in_buffer_pkg
// Shared NIC constants: flit type encodings, reassembly FSM states and
// default geometry used by the ingress flit buffer.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package fifo_in_buffer_pkg;

  // Default link geometry; overridable per instance.
  localparam int DEF_FLIT_WIDTH        = 16;
  localparam int DEF_MAX_PACKET_LENGHT = 5;
  localparam int DEF_N_OF_VN           = 2;

  // Flit type lives in the two MSBs of every flit; the egress flit builder
  // uses the same encoding.
  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  // Reassembly FSM states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  // clog2 that never returns zero, so single-value fields keep one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_in_buffer_credit_return.sv
// -----------------------------------------------------------------------------
// fifo_in_buffer_credit_return
// Pending-credit counter: adds a packet length on load, drains one credit
// per cycle and emits a one-cycle pulse for each credit drained.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_in_buffer_credit_return #(
  parameter int N_BITS_CREDIT        = 5,
  parameter int N_BITS_PACKET_LENGHT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_i,
  input  logic [N_BITS_PACKET_LENGHT-1:0] len_i,
  output logic                            credit_out_o
);

  logic [N_BITS_CREDIT-1:0] cnt_q;
  logic [N_BITS_CREDIT-1:0] cnt_d;
  logic [N_BITS_CREDIT-1:0] add;
  logic [N_BITS_CREDIT-1:0] dec;

  // A load and a drain in the same cycle net out to len-1, so back-to-back
  // packets produce an unbroken pulse train.
  always_comb begin
    add   = load_i ? N_BITS_CREDIT'(len_i) : '0;
    dec   = {{(N_BITS_CREDIT-1){1'b0}}, (cnt_q != '0)};
    cnt_d = cnt_q + add - dec;
  end

  // Counter register; reset discards any credits still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign credit_out_o = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/fifo_in_buffer.sv
// -----------------------------------------------------------------------------
// fifo_in_buffer
// Ingress buffer for one input VC: reassembles flits from the router link
// into a packet, hands it to the NIC core and returns credits once consumed.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_in_buffer
  import fifo_in_buffer_pkg::*;
#(
  parameter int  FLIT_WIDTH           = DEF_FLIT_WIDTH,
  parameter int  MAX_PACKET_LENGHT    = DEF_MAX_PACKET_LENGHT,
  parameter int  N_OF_VN              = DEF_N_OF_VN,
  parameter int  MAX_CREDIT           = 2 * MAX_PACKET_LENGHT,
  localparam int N_BITS_VNET_ID       = clog2_min1(N_OF_VN),
  localparam int N_BITS_CREDIT        = $clog2(MAX_CREDIT) + 1,
  localparam int N_BITS_PACKET_LENGHT = $clog2(MAX_PACKET_LENGHT) + 1,
  localparam int PKT_WIDTH            = MAX_PACKET_LENGHT * FLIT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [FLIT_WIDTH-1:0]           flit_i,
  input  logic                            is_valid_i,
  output logic                            credit_out_o,
  output logic [PKT_WIDTH-1:0]            pkt_o,
  output logic [N_BITS_PACKET_LENGHT-1:0] pkt_length_o,
  output logic [N_BITS_VNET_ID-1:0]       vnet_id_o,
  output logic                            pkt_valid_o,
  input  logic                            pkt_ack_i,
  output logic                            free_slot_o,
  output logic                            error_o
);

  logic [1:0]                      state_q, state_d;
  logic [PKT_WIDTH-1:0]            pkt_q, pkt_d;
  logic [N_BITS_PACKET_LENGHT-1:0] count_q, count_d;
  logic [N_BITS_VNET_ID-1:0]       vnet_q, vnet_d;
  logic                            error_q, error_d;

  flit_type_e ftype;
  logic       is_head;
  logic       is_cont;
  logic       has_room;
  logic       ack_accept;

  assign ftype      = flit_type_e'(flit_i[FLIT_WIDTH-1 -: 2]);
  assign is_head    = (ftype == FLIT_HEAD) || (ftype == FLIT_HEADTAIL);
  assign is_cont    = (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
  assign has_room   = (count_q < N_BITS_PACKET_LENGHT'(MAX_PACKET_LENGHT));
  // An ack is only meaningful while a complete packet is being presented.
  assign ack_accept = pkt_ack_i && (state_q == S_FULL);

  // Reassembly next-state: illegal flits are dropped and only raise the sticky
  // error flag, leaving FSM and packet contents untouched.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    count_d = count_q;
    vnet_d  = vnet_q;
    error_d = error_q;

    if (is_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (is_head) begin
            pkt_d                   = '0;
            pkt_d[FLIT_WIDTH-1:0]   = flit_i;
            count_d                 = N_BITS_PACKET_LENGHT'(1);
            vnet_d                  = flit_i[FLIT_WIDTH-3 -: N_BITS_VNET_ID];
            state_d                 = (ftype == FLIT_HEADTAIL) ? S_FULL : S_RECV;
          end else begin
            error_d = 1'b1;
          end
        end
        S_RECV: begin
          if (is_cont && has_room) begin
            for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
              if (count_q == N_BITS_PACKET_LENGHT'(k)) begin
                pkt_d[k*FLIT_WIDTH +: FLIT_WIDTH] = flit_i;
              end
            end
            count_d = count_q + N_BITS_PACKET_LENGHT'(1);
            if (ftype == FLIT_TAIL) begin
              state_d = S_FULL;
            end
          end else begin
            error_d = 1'b1;
          end
        end
        default: begin
          // Packet held for the core: no slot for another flit.
          error_d = 1'b1;
        end
      endcase
    end

    if (ack_accept) begin
      state_d = S_IDLE;
    end
  end

  // Reassembly state registers; reset drops any partially received packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      count_q <= '0;
      vnet_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      count_q <= count_d;
      vnet_q  <= vnet_d;
      error_q <= error_d;
    end
  end

  fifo_in_buffer_credit_return #(
    .N_BITS_CREDIT        (N_BITS_CREDIT),
    .N_BITS_PACKET_LENGHT (N_BITS_PACKET_LENGHT)
  ) u_credit_return (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ack_accept),
    .len_i        (count_q),
    .credit_out_o (credit_out_o)
  );

  assign pkt_o        = pkt_q;
  assign pkt_length_o = count_q;
  assign vnet_id_o    = vnet_q;
  assign pkt_valid_o  = (state_q == S_FULL);
  assign free_slot_o  = (state_q == S_IDLE);
  assign error_o      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_in_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_in_buffer
// Directed self-checking bench for the ingress flit buffer
// (FLIT_WIDTH=16, MAX_PACKET_LENGHT=5, N_OF_VN=2).
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_in_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] flit_i;
  logic        is_valid_i;
  logic        credit_out_o;
  logic [79:0] pkt_o;
  logic [3:0]  pkt_length_o;
  logic [0:0]  vnet_id_o;
  logic        pkt_valid_o;
  logic        pkt_ack_i;
  logic        free_slot_o;
  logic        error_o;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_in_buffer #(
    .FLIT_WIDTH        (16),
    .MAX_PACKET_LENGHT (5),
    .N_OF_VN           (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flit_i       (flit_i),
    .is_valid_i   (is_valid_i),
    .credit_out_o (credit_out_o),
    .pkt_o        (pkt_o),
    .pkt_length_o (pkt_length_o),
    .vnet_id_o    (vnet_id_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ack_i    (pkt_ack_i),
    .free_slot_o  (free_slot_o),
    .error_o      (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] f;
    logic        a;
    logic        e_valid;
    logic [3:0]  e_len;
    logic        e_vnet;
    logic        e_cr;
    logic        e_free;
    logic        e_err;
    logic        chk_pkt;
    logic [79:0] e_pkt;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [15:0] f, input logic a);
    is_valid_i = v;
    flit_i     = f;
    pkt_ack_i  = a;
    @(posedge clk);
    #1;
    is_valid_i = 1'b0;
    flit_i     = 16'h0;
    pkt_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    is_valid_i = 1'b0;
    flit_i     = 16'h0;
    pkt_ack_i  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pkt"},   pkt_o,        80'h0);
    chk({tag, " len"},   pkt_length_o, 80'h0);
    chk({tag, " vnet"},  vnet_id_o,    80'h0);
    chk({tag, " valid"}, pkt_valid_o,  80'h0);
    chk({tag, " cr"},    credit_out_o, 80'h0);
    chk({tag, " free"},  free_slot_o,  80'h1);
    chk({tag, " err"},   error_o,      80'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    //            v  flit      a  val len vn cr fr er chk pkt
    // Five-flit packet, ack, five credit pulses (ack in IDLE at 10 ignored).
    tbl[0]  = '{1'b1, 16'h4001, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'h4001};
    tbl[1]  = '{1'b1, 16'h0BBB, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0};
    tbl[2]  = '{1'b1, 16'h0CCC, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0};
    tbl[3]  = '{1'b1, 16'h0DDD, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0};
    tbl[4]  = '{1'b1, 16'h8FFF, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'h8FFF0DDD0CCC0BBB4001};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80'h0};
    // Head-tail on vnet 1, one credit; stray ack at 13 ignored.
    tbl[11] = '{1'b1, 16'hE123, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 80'hE123};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 80'h0};
    // Three-flit packet; head-tail arrives during 2nd pulse, acked at once.
    tbl[14] = '{1'b1, 16'h4111, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0};
    tbl[15] = '{1'b1, 16'h0222, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0};
    tbl[16] = '{1'b1, 16'h8333, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'h833302224111};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[19] = '{1'b1, 16'hC000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 80'hC000};
    tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0};
    tbl[21] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80'h0};

    rst_n      = 1'b0;
    is_valid_i = 1'b0;
    flit_i     = 16'h0;
    pkt_ack_i  = 1'b0;
    #1;
    chk_reset_state("por");
    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].v, tbl[i].f, tbl[i].a);
      chk($sformatf("v%0d valid", i), pkt_valid_o,  tbl[i].e_valid);
      chk($sformatf("v%0d len", i),   pkt_length_o, tbl[i].e_len);
      chk($sformatf("v%0d vnet", i),  vnet_id_o,    tbl[i].e_vnet);
      chk($sformatf("v%0d cr", i),    credit_out_o, tbl[i].e_cr);
      chk($sformatf("v%0d free", i),  free_slot_o,  tbl[i].e_free);
      chk($sformatf("v%0d err", i),   error_o,      tbl[i].e_err);
      if (tbl[i].chk_pkt) chk($sformatf("v%0d pkt", i), pkt_o, tbl[i].e_pkt);
    end

    // Protocol violations: each flit dropped, error sticky, held packet intact.
    cyc(1'b1, 16'h0AAA, 1'b0);
    chk("viol body-idle err", error_o, 80'h1);
    chk("viol body-idle free", free_slot_o, 80'h1);
    cyc(1'b1, 16'h4555, 1'b0);
    chk("viol head len", pkt_length_o, 80'h1);
    cyc(1'b1, 16'h4666, 1'b0);
    chk("viol head-recv len", pkt_length_o, 80'h1);
    chk("viol head-recv pkt", pkt_o, 80'h4555);
    chk("viol head-recv free", free_slot_o, 80'h0);
    cyc(1'b1, 16'h8777, 1'b0);
    chk("viol tail valid", pkt_valid_o, 80'h1);
    chk("viol tail pkt", pkt_o, 80'h87774555);
    cyc(1'b1, 16'h0999, 1'b0);
    chk("viol full valid", pkt_valid_o, 80'h1);
    chk("viol full len", pkt_length_o, 80'h2);
    chk("viol full pkt", pkt_o, 80'h87774555);
    chk("viol full err", error_o, 80'h1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("viol ack cr", credit_out_o, 80'h1);
    cyc(1'b0, 16'h0, 1'b0);
    chk("viol drain cr1", credit_out_o, 80'h1);
    cyc(1'b0, 16'h0, 1'b0);
    chk("viol drain cr0", credit_out_o, 80'h0);
    chk("viol err sticky", error_o, 80'h1);

    // Overlength packet: sixth flit dropped, FSM stays receiving.
    do_reset();
    chk_reset_state("reset2");
    cyc(1'b1, 16'h4010, 1'b0);
    for (int k = 1; k < 5; k++) cyc(1'b1, 16'h0010 + 16'(k), 1'b0);
    chk("ovl len5", pkt_length_o, 80'h5);
    chk("ovl err before", error_o, 80'h0);
    cyc(1'b1, 16'h0015, 1'b0);
    chk("ovl err", error_o, 80'h1);
    chk("ovl len", pkt_length_o, 80'h5);
    chk("ovl pkt", pkt_o, 80'h00140013001200114010);
    chk("ovl free", free_slot_o, 80'h0);
    cyc(1'b1, 16'h8016, 1'b0);
    chk("ovl tail valid", pkt_valid_o, 80'h0);
    chk("ovl tail len", pkt_length_o, 80'h5);

    // Asynchronous reset mid-packet while credits are still draining.
    do_reset();
    cyc(1'b1, 16'h4041, 1'b0);
    cyc(1'b1, 16'h0042, 1'b0);
    cyc(1'b1, 16'h0043, 1'b0);
    cyc(1'b1, 16'h0044, 1'b0);
    cyc(1'b1, 16'h8045, 1'b0);
    chk("rst pre valid", pkt_valid_o, 80'h1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h4030, 1'b0);
    cyc(1'b1, 16'h0031, 1'b0);
    cyc(1'b1, 16'h4032, 1'b0);
    chk("rst pre err", error_o, 80'h1);
    chk("rst pre cr", credit_out_o, 80'h1);
    chk("rst pre len", pkt_length_o, 80'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst cr%0d", k), credit_out_o, 80'h0);
    end
    cyc(1'b1, 16'h6100, 1'b0);
    cyc(1'b1, 16'hA200, 1'b0);
    chk("clean valid", pkt_valid_o, 80'h1);
    chk("clean len", pkt_length_o, 80'h2);
    chk("clean vnet", vnet_id_o, 80'h1);
    chk("clean pkt", pkt_o, 80'hA2006100);
    chk("clean err", error_o, 80'h0);
    cyc(1'b0, 16'h0, 1'b1);
    pulses = int'(credit_out_o);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 16'h0, 1'b0);
      pulses += int'(credit_out_o);
    end
    chk("clean pulses", 80'(pulses), 80'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
